// File: rtl/fifo_read_packer.sv
// Read-domain FIFO consumer: pops one byte every two cycles, packs BYTES_PER_WORD bytes into a
// word and hands it downstream on valid/ready with an XOR checksum and an accepted-word counter.
module fifo_read_packer #(
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned BYTES_PER_WORD = 4,
    parameter int unsigned CNT_WIDTH      = 16
) (
    input  logic                               rd_clk,
    input  logic                               reset,
    input  logic                               r_empty,
    input  logic [DATA_WIDTH-1:0]              fifo_data,
    output logic                               rd_en,
    output logic [DATA_WIDTH*BYTES_PER_WORD-1:0] word_out,
    output logic [DATA_WIDTH-1:0]              word_parity,
    output logic                               word_valid,
    input  logic                               word_ready,
    output logic [CNT_WIDTH-1:0]               word_count,
    output logic                               busy
);

    localparam int unsigned WordWidth = DATA_WIDTH * BYTES_PER_WORD;
    localparam int unsigned IdxWidth  = $clog2(BYTES_PER_WORD);

    typedef enum logic [1:0] {StFill, StCapture, StOut} state_t;

    state_t                state_q, state_d;
    logic [IdxWidth-1:0]   byte_idx_q, byte_idx_d;
    logic [WordWidth-1:0]  shift_q, shift_d;
    logic [DATA_WIDTH-1:0] acc_q, acc_d;
    logic [WordWidth-1:0]  word_q, word_d;
    logic [DATA_WIDTH-1:0] parity_q, parity_d;
    logic                  valid_q, valid_d;
    logic [CNT_WIDTH-1:0]  count_q, count_d;

    always_comb begin
        state_d    = state_q;
        byte_idx_d = byte_idx_q;
        shift_d    = shift_q;
        acc_d      = acc_q;
        word_d     = word_q;
        parity_d   = parity_q;
        valid_d    = valid_q;
        count_d    = count_q;
        // Reset gates the pop so nothing leaves the FIFO while it is being cleared.
        rd_en      = 1'b0;

        unique case (state_q)
            StFill: begin
                rd_en = ~r_empty & ~reset;
                if (!r_empty) begin
                    state_d = StCapture;
                end
            end
            StCapture: begin
                shift_d[byte_idx_q*DATA_WIDTH +: DATA_WIDTH] = fifo_data;
                acc_d = acc_q ^ fifo_data;
                if (byte_idx_q == IdxWidth'(BYTES_PER_WORD - 1)) begin
                    word_d     = shift_d;
                    parity_d   = acc_d;
                    valid_d    = 1'b1;
                    byte_idx_d = '0;
                    acc_d      = '0;
                    state_d    = StOut;
                end else begin
                    byte_idx_d = byte_idx_q + IdxWidth'(1);
                    state_d    = StFill;
                end
            end
            StOut: begin
                if (word_ready) begin
                    valid_d = 1'b0;
                    count_d = count_q + CNT_WIDTH'(1);
                    state_d = StFill;
                end
            end
            default: state_d = StFill;
        endcase
    end

    always_ff @(posedge rd_clk or posedge reset) begin
        if (reset) begin
            state_q    <= StFill;
            byte_idx_q <= '0;
            shift_q    <= '0;
            acc_q      <= '0;
            word_q     <= '0;
            parity_q   <= '0;
            valid_q    <= 1'b0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            byte_idx_q <= byte_idx_d;
            shift_q    <= shift_d;
            acc_q      <= acc_d;
            word_q     <= word_d;
            parity_q   <= parity_d;
            valid_q    <= valid_d;
            count_q    <= count_d;
        end
    end

    assign word_out    = word_q;
    assign word_parity = parity_q;
    assign word_valid  = valid_q;
    assign word_count  = count_q;
    assign busy        = (state_q != StFill) || (byte_idx_q != '0);

endmodule

// File: doc/fifo_read_packer.md
Name: fifo_read_packer

Overview:
- Read-side consumer of the async FIFO, clocked in the read domain.
- Pops bytes from the FIFO read port whenever the FIFO is not empty and packs BYTES_PER_WORD bytes into one wide word.
- Presents each word downstream on a valid/ready handshake, with a per-word XOR checksum and a running word count.
- Applies backpressure by not popping the FIFO while a word is held un-accepted.

Parameters:
- DATA_WIDTH, 8, width of one FIFO entry (byte).
- BYTES_PER_WORD, 4, entries packed per output word; must be ≥2.
- CNT_WIDTH, 16, width of the word counter.

Ports:
- rd_clk  input  1  read-domain clock; all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- r_empty  input  1  FIFO empty flag, rd_clk domain.
- fifo_data  input  DATA_WIDTH  FIFO data_out; valid the cycle after rd_en is sampled high.
- rd_en  output  1  FIFO pop request; combinational from state and r_empty.
- word_out  output  DATA_WIDTH*BYTES_PER_WORD  packed word; first popped byte in bits [DATA_WIDTH-1:0].
- word_parity  output  DATA_WIDTH  XOR of all bytes in word_out.
- word_valid  output  1  word_out/word_parity valid.
- word_ready  input  1  downstream accepts the word.
- word_count  output  CNT_WIDTH  words accepted since reset; wraps at 2^CNT_WIDTH.
- busy  output  1  high when state ≠ FILL or byte_idx ≠ 0.

Behaviour:
- Reset (async assert, released on rd_clk):
  - state=FILL, byte_idx=0, shift register=0, parity accumulator=0.
  - word_out=0, word_parity=0, word_valid=0, word_count=0, rd_en=0, busy=0.
- FIFO read latency is fixed at 1 cycle.
- At most one pop is in flight; throughput is 1 byte per 2 cycles.
- States:
  - FILL: rd_en = ~r_empty. If rd_en is high → CAPTURE; otherwise stay.
  - CAPTURE: rd_en=0.
    - Write fifo_data into byte lane byte_idx; XOR it into the parity accumulator.
    - If byte_idx == BYTES_PER_WORD-1 → OUT: load word_out and word_parity from the completed values, word_valid=1, byte_idx=0, clear the accumulator.
    - Otherwise byte_idx+1 → FILL.
  - OUT: rd_en=0. word_out and word_parity stay stable while word_valid=1. On word_valid & word_ready: word_valid=0, word_count+1 (modulo), → FILL.
- Timing:
  - Earliest rd_en for the next word is the cycle after acceptance.
  - Minimum word period is 2*BYTES_PER_WORD+1 cycles when the FIFO is never empty and word_ready is tied high.
- Boundary conditions:
  - r_empty high in FILL: no pop; a partial word is held indefinitely; no timeout, no flush.
  - r_empty rising during CAPTURE: no effect; that byte was already popped.
  - word_ready high while word_valid=0: ignored.
  - word_ready low: OUT is held; the FIFO is not popped, so backpressure reaches w_full upstream.
  - word_count at all-ones with acceptance: wraps to 0.
  - Reset mid-word or mid-OUT: the partial or held word is discarded; an in-flight byte is lost (FIFO is reset together).
- rd_en must never be asserted while r_empty=1 (no underflow pops).

Test Plan:
- Reset, r_empty=1 for 20 cycles → rd_en=0, word_valid=0, word_count=0, busy=0.
- FIFO supplies 0x11,0x22,0x33,0x44, word_ready=1 → word_out=0x44332211, word_parity=0x44, word_valid high 1 cycle, word_count=1; word period is 9 cycles.
- Bytes 0xAA,0x55,0xFF,0x00 with word_ready=0 for 10 cycles → word_out=0x00FF55AA and word_parity=0x00 held stable; rd_en=0 throughout despite r_empty=0. On word_ready=1 → count increments and the next pop follows 1 cycle later.
- r_empty toggled randomly mid-word → bytes packed in pop order, no gaps or duplicates; rd_en never high when r_empty=1.
- Reset asserted after 2 bytes of a word → outputs cleared immediately (async). The next 4 bytes 0x01..0x04 give 0x04030201.
- CNT_WIDTH=4, 17 words accepted → word_count wraps 15→0 and reads 1.
